vga_pixel_pipe: RTL and testbench

- Parametrised VGA timing generator and pixel output stage; successor to the fixed 640x480, 1-bit-per-channel top.
- Produces hsync/vsync, pixel coordinate requests to an upstream pixel source, and pipeline-aligned RGB.
- Colour depth, resolution/porches, pixel-clock divide, source latency and output mode are configurable.
- Sits between the character/bitmap renderer and the board VGA pins.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/vga_pixel_pipe.sv | 175 +++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel pipe: output mode encodings,
// default 640x480@60 timing and the counter-width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BG    = 2'd0,
    MODE_PASS  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_BLACK = 2'd3
  } vga_mode_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register of configurable width and depth; keeps
// sync, enable and column flags in step with the pixel source latency.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            stage_reg[gi] <= '0;
          end else if (tick) begin
            stage_reg[gi] <= d;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            stage_reg[gi] <= '0;
          end else if (tick) begin
            stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Parametrised VGA timing generator and registered RGB output stage.
// Build option: define VGA_TEST_PATTERN_EN to enable colour bars in mode 2.
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA_H_ACTIVE,
  parameter int   H_FP       = VGA_H_FP,
  parameter int   H_SYNC     = VGA_H_SYNC,
  parameter int   H_BP       = VGA_H_BP,
  parameter int   V_ACTIVE   = VGA_V_ACTIVE,
  parameter int   V_FP       = VGA_V_FP,
  parameter int   V_SYNC     = VGA_V_SYNC,
  parameter int   V_BP       = VGA_V_BP,
  parameter int   CLK_DIV    = 1,
  parameter int   COLOR_BITS = 2,
  parameter int   PIPE_LAT   = 2,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic [COLOR_BITS-1:0]         BP_R,
  input  logic [COLOR_BITS-1:0]         BP_G,
  input  logic [COLOR_BITS-1:0]         BP_B,
  output logic [cnt_w(H_ACTIVE)-1:0]    req_x,
  output logic [cnt_w(V_ACTIVE)-1:0]    req_y,
  output logic                          req_valid,
  output logic                          pix_tick,
  input  logic [3*COLOR_BITS-1:0]       pix_rgb,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic [3*COLOR_BITS-1:0]       rgb,
  output logic                          frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW    = cnt_w(H_ACTIVE);
  localparam int YW    = cnt_w(V_ACTIVE);
  localparam int HW    = cnt_w(H_TOT + 1);
  localparam int VW    = cnt_w(V_TOT + 1);
  localparam int DW    = cnt_w(CLK_DIV);
  localparam int RGB_W = 3 * COLOR_BITS;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_S  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYN_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN_S  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYN_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam int DL_W = 4 + XW;
`else
  localparam int DL_W = 4;
`endif

  logic [DW-1:0]    div_cnt_reg;
  logic [HW-1:0]    h_cnt_reg;
  logic [VW-1:0]    v_cnt_reg;
  logic             run_reg;
  vga_mode_e        mode_reg;
  logic             de_raw;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             frame_raw;
  logic [DL_W-1:0]  dl_in;
  logic [DL_W-1:0]  dl_out;
  logic [RGB_W-1:0] rgb_sel;

  // run_reg holds the strobe off until the first edge after reset release,
  // so pix_tick and req_valid read 0 while in reset even with CLK_DIV = 1.
  assign pix_tick  = run_reg && (div_cnt_reg == DIV_LAST);
  assign de_raw    = (h_cnt_reg < H_ACT_L) && (v_cnt_reg < V_ACT_L);
  assign hsync_raw = (h_cnt_reg >= H_SYN_S) && (h_cnt_reg < H_SYN_E);
  assign vsync_raw = (v_cnt_reg >= V_SYN_S) && (v_cnt_reg < V_SYN_E);
  assign frame_raw = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign req_valid = run_reg && de_raw;
  assign req_x     = de_raw ? XW'(h_cnt_reg) : '0;
  assign req_y     = de_raw ? YW'(v_cnt_reg) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      run_reg     <= 1'b0;
      mode_reg    <= MODE_BG;
    end else begin
      run_reg     <= 1'b1;
      div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DW'(1);
      if (pix_tick) begin
        // Mode only changes on the request of pixel (0,0), never mid-frame.
        if (frame_raw) begin
          mode_reg <= vga_mode_e'(mode);
        end
        if (h_cnt_reg == H_LAST) begin
          h_cnt_reg <= '0;
          v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
        end else begin
          h_cnt_reg <= h_cnt_reg + HW'(1);
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  assign dl_in = {req_x, frame_raw, de_raw, vsync_raw, hsync_raw};
`else
  assign dl_in = {frame_raw, de_raw, vsync_raw, hsync_raw};
`endif

  vga_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (PIPE_LAT)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick),
    .d    (dl_in),
    .q    (dl_out)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [XW-1:0]    x_out;
  logic [2:0]       bar_idx;
  logic [RGB_W-1:0] bar_rgb;

  assign x_out   = dl_out[DL_W-1:4];
  assign bar_idx = 3'((int'(x_out) * 8) / H_ACTIVE);

  genvar gi;
  generate
    // Slice 0 is blue (LSBs) and follows bar bit 0; red follows bit 2.
    for (gi = 0; gi < 3; gi++) begin : g_bar
      assign bar_rgb[gi*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{bar_idx[gi]}};
    end
  endgenerate
`endif

  always_comb begin
    rgb_sel = '0;
    case (mode_reg)
      MODE_BG:   rgb_sel = {BP_R, BP_G, BP_B};
      MODE_PASS: rgb_sel = pix_rgb;
`ifdef VGA_TEST_PATTERN_EN
      MODE_BARS: rgb_sel = bar_rgb;
`endif
      default:   rgb_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && dl_out[3] && dl_out[2];
      if (pix_tick) begin
        hsync <= dl_out[0] ? SYNC_POL : ~SYNC_POL;
        vsync <= dl_out[1] ? SYNC_POL : ~SYNC_POL;
        de    <= dl_out[2];
        rgb   <= dl_out[2] ? rgb_sel : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Random-stimulus bench for vga_pixel_pipe: two instances (CLK_DIV 1 and 4) on a
// tiny 8x4 raster, checked every clk against a tick-count based frame model.
`timescale 1ns/1ps
module tb_vga_pixel_pipe;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PL = 2;
  localparam int TAB_N = 97;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd1;
  logic [1:0] bp_r = 2'd0;
  logic [1:0] bp_g = 2'd0;
  logic [1:0] bp_b = 2'd0;

  logic [5:0] pix_rgb_s     [2];
  logic [2:0] req_x_s       [2];
  logic [1:0] req_y_s       [2];
  logic       req_valid_s   [2];
  logic       pix_tick_s    [2];
  logic       hsync_s       [2];
  logic       vsync_s       [2];
  logic       de_s          [2];
  logic [5:0] rgb_s         [2];
  logic       frame_start_s [2];

  always #5 clk = ~clk;

  vga_pixel_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(1), .COLOR_BITS(2), .PIPE_LAT(PL), .SYNC_POL(1'b0)
  ) u_dut_div1 (
    .clk(clk), .rst(rst), .mode(mode), .BP_R(bp_r), .BP_G(bp_g), .BP_B(bp_b),
    .req_x(req_x_s[0]), .req_y(req_y_s[0]), .req_valid(req_valid_s[0]),
    .pix_tick(pix_tick_s[0]), .pix_rgb(pix_rgb_s[0]), .hsync(hsync_s[0]),
    .vsync(vsync_s[0]), .de(de_s[0]), .rgb(rgb_s[0]), .frame_start(frame_start_s[0])
  );

  vga_pixel_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(4), .COLOR_BITS(2), .PIPE_LAT(PL), .SYNC_POL(1'b0)
  ) u_dut_div4 (
    .clk(clk), .rst(rst), .mode(mode), .BP_R(bp_r), .BP_G(bp_g), .BP_B(bp_b),
    .req_x(req_x_s[1]), .req_y(req_y_s[1]), .req_valid(req_valid_s[1]),
    .pix_tick(pix_tick_s[1]), .pix_rgb(pix_rgb_s[1]), .hsync(hsync_s[1]),
    .vsync(vsync_s[1]), .de(de_s[1]), .rgb(rgb_s[1]), .frame_start(frame_start_s[1])
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         k = 0;
  int         n_tk [2] = '{0, 0};
  bit         last_tick [2] = '{1'b0, 1'b0};
  int         fmode [2][64];
  logic [5:0] bg_at [2];
  logic [5:0] tab [TAB_N];
  bit         rand_en = 1'b0;
  logic       rst_cmd = 1'b0;

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Tick index r since release maps straight onto a raster position.
  function automatic int hpos(input int r);
    return r % HT;
  endfunction

  function automatic int vpos(input int r);
    return (r / HT) % VT;
  endfunction

  function automatic bit act(input int r);
    return (hpos(r) < HA) && (vpos(r) < VA);
  endfunction

  function automatic logic [5:0] src(input int r);
    return (r < 0) ? 6'd0 : tab[r % TAB_N];
  endfunction

  function automatic bit exp_tick(input int d, input int kk);
    int dv;
    dv = div_of(d);
    return (kk >= 1) && ((kk % dv) == dv - 1);
  endfunction

  task automatic check(input int d, input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL div%0d.%s t=%0t: got %0d, expected %0d", div_of(d), tag, $time, got, exp);
    end
  endtask

  task automatic check_idle(input int d);
    check(d, "hsync", int'(hsync_s[d]), 1);
    check(d, "vsync", int'(vsync_s[d]), 1);
    check(d, "de", int'(de_s[d]), 0);
    check(d, "rgb", int'(rgb_s[d]), 0);
    check(d, "frame_start", int'(frame_start_s[d]), 0);
  endtask

  task automatic check_cycle(input int d);
    int         r, hp, vp, m, e_rgb;
    bit         t;
    logic [2:0] bar;
    if (!rst) begin
      check(d, "rst_pix_tick", int'(pix_tick_s[d]), 0);
      check(d, "rst_req_valid", int'(req_valid_s[d]), 0);
      check_idle(d);
    end else begin
      t = exp_tick(d, k);
      check(d, "pix_tick", int'(pix_tick_s[d]), int'(t));
      if (t) begin
        check(d, "req_valid", int'(req_valid_s[d]), int'(act(n_tk[d])));
        check(d, "req_x", int'(req_x_s[d]), act(n_tk[d]) ? hpos(n_tk[d]) : 0);
        check(d, "req_y", int'(req_y_s[d]), act(n_tk[d]) ? vpos(n_tk[d]) : 0);
      end
      r = n_tk[d] - 1 - PL;
      if (r < 0) begin
        check_idle(d);
      end else begin
        hp = hpos(r);
        vp = vpos(r);
        e_rgb = 0;
        if (act(r)) begin
          m = fmode[d][(r / FT) % 64];
          bar = 3'((hp * 8) / HA);
          case (m)
            0: e_rgb = int'(bg_at[d]);
            1: e_rgb = int'(src(r));
`ifdef VGA_TEST_PATTERN_EN
            2: e_rgb = int'({{2{bar[2]}}, {2{bar[1]}}, {2{bar[0]}}});
`endif
            default: e_rgb = 0;
          endcase
        end
        check(d, "hsync", int'(hsync_s[d]), int'(!(hp >= HA + HF && hp < HA + HF + HS)));
        check(d, "vsync", int'(vsync_s[d]), int'(!(vp >= VA + VF && vp < VA + VF + VS)));
        check(d, "de", int'(de_s[d]), int'(act(r)));
        check(d, "rgb", int'(rgb_s[d]), e_rgb);
        check(d, "frame_start", int'(frame_start_s[d]),
              int'(last_tick[d] && hp == 0 && vp == 0));
      end
    end
  endtask

  // One clk: advance the model at the edge, drive inputs just after it,
  // then check both instances on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        last_tick[d] = exp_tick(d, k);
        if (last_tick[d]) begin
          if (hpos(n_tk[d]) == 0 && vpos(n_tk[d]) == 0) begin
            fmode[d][(n_tk[d] / FT) % 64] = int'(mode);
          end
          bg_at[d] = {bp_r, bp_g, bp_b};
          n_tk[d]++;
        end
      end
      k++;
    end
    #1;
    if (rst_cmd != rst) begin
      rst = rst_cmd;
      if (!rst_cmd) begin
        k = 0;
        for (int d = 0; d < 2; d++) begin
          n_tk[d] = 0;
          last_tick[d] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      pix_rgb_s[d] = src(n_tk[d] - PL);
    end
    if (rand_en) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        bp_r = 2'($urandom_range(0, 3));
        bp_g = 2'($urandom_range(0, 3));
        bp_b = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < TAB_N; i++) tab[i] = 6'($urandom_range(0, 63));
    for (int d = 0; d < 2; d++) begin
      pix_rgb_s[d] = 6'd0;
      bg_at[d] = 6'd0;
    end

    rst_cmd = 1'b0;
    repeat (4) step();
    $display("phase reset: compared=%0d mismatched=%0d", n_cmp, n_bad);

    rst_cmd = 1'b1;
    mode = 2'd1;
    repeat (500) step();
    $display("phase pass-through: compared=%0d mismatched=%0d", n_cmp, n_bad);

    mode = 2'd0;
    bp_r = 2'b10;
    bp_g = 2'b01;
    bp_b = 2'b11;
    repeat (300) step();
    mode = 2'd1;
    repeat (200) step();
    $display("phase background/mode-switch: compared=%0d mismatched=%0d", n_cmp, n_bad);

    rand_en = 1'b1;
    repeat (900) step();
    $display("phase random: compared=%0d mismatched=%0d", n_cmp, n_bad);

    guard = 0;
    while (!(hpos(n_tk[0]) == 5 && vpos(n_tk[0]) == 2) && guard < 200) begin
      step();
      guard++;
    end
    rst_cmd = 1'b0;
    repeat (3) step();
    rst_cmd = 1'b1;
    repeat (700) step();
    $display("phase mid-frame reset: compared=%0d mismatched=%0d", n_cmp, n_bad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
